// File: rtl/systolic_mm_array.sv
// Output-stationary systolic matrix-multiply engine computing C = A * W.
// Operands enter once per accepted beat, are skewed on chip so that beat k
// meets at PE(i,j) i+j cycles after PE(0,0), and every PE keeps its own
// accumulator. Finished rows are streamed out one at a time with valid/ready.
module systolic_mm_array #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24,
    parameter int K_MAX  = 256,
    parameter int SIGNED = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic [$clog2(K_MAX+1)-1:0]             k_len,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [ROWS*DATA_W-1:0]                 in_a,
    input  logic [COLS*DATA_W-1:0]                 in_w,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [COLS*ACC_W-1:0]                  out_row,
    output logic [(ROWS > 1 ? $clog2(ROWS) : 1)-1:0] out_idx,
    output logic                                   busy,
    output logic                                   done
);

    localparam int KW = $clog2(K_MAX + 1);
    localparam int IW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DW = $clog2(ROWS + COLS);
    localparam int PW = 2 * DATA_W;

    // A product must always fit in the accumulator.
    if (ACC_W < PW) begin : g_acc_width_check
        $error("systolic_mm_array: ACC_W must be at least 2*DATA_W");
    end

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        OUT
    } state_t;

    state_t          state;
    logic [KW-1:0]   k_lat;
    logic [KW-1:0]   kc;
    logic [DW-1:0]   dc;

    logic            accept;
    logic            clear_acc;

    assign accept    = in_valid & in_ready;
    assign clear_acc = (state == IDLE) & start;

    // Per-PE operand taps (data plus valid tag) after skew and forwarding.
    logic [DATA_W-1:0] a_tap   [ROWS][COLS];
    logic              a_tap_v [ROWS][COLS];
    logic [DATA_W-1:0] w_tap   [ROWS][COLS];
    logic              w_tap_v [ROWS][COLS];

    logic [ACC_W-1:0]  acc     [ROWS][COLS];

    // Full-width product, sign- or zero-extended to the accumulator width.
    function automatic logic [ACC_W-1:0] mac_term(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] w);
        logic signed [PW-1:0] ps;
        logic [PW-1:0]        pu;
        logic [ACC_W-1:0]     term;
        ps = PW'($signed(a)) * PW'($signed(w));
        pu = PW'(a) * PW'(w);
        if (SIGNED != 0) term = ACC_W'(ps);
        else             term = ACC_W'(pu);
        return term;
    endfunction

    // Row i of A: i skew stages followed by one stage per PE hop eastwards,
    // so PE(i,j) taps stage i+j of a single shift chain.
    for (genvar i = 0; i < ROWS; i++) begin : g_arow
        localparam int LEN = i + COLS;
        logic [DATA_W-1:0] sr_d [LEN];
        logic              sr_v [LEN];

        // Shift row operand and its valid tag one stage every cycle; idle cycles inject bubbles.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < LEN; s++) begin
                    sr_d[s] <= '0;
                    sr_v[s] <= 1'b0;
                end
            end else begin
                sr_d[0] <= in_a[i*DATA_W +: DATA_W];
                sr_v[0] <= accept;
                for (int s = 1; s < LEN; s++) begin
                    sr_d[s] <= sr_d[s-1];
                    sr_v[s] <= sr_v[s-1];
                end
            end
        end

        for (genvar j = 0; j < COLS; j++) begin : g_tap
            assign a_tap[i][j]   = sr_d[i+j];
            assign a_tap_v[i][j] = sr_v[i+j];
        end
    end

    // Column j of W: j skew stages followed by one stage per PE hop southwards.
    for (genvar j = 0; j < COLS; j++) begin : g_wcol
        localparam int LEN = j + ROWS;
        logic [DATA_W-1:0] sr_d [LEN];
        logic              sr_v [LEN];

        // Shift column operand and its valid tag one stage every cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < LEN; s++) begin
                    sr_d[s] <= '0;
                    sr_v[s] <= 1'b0;
                end
            end else begin
                sr_d[0] <= in_w[j*DATA_W +: DATA_W];
                sr_v[0] <= accept;
                for (int s = 1; s < LEN; s++) begin
                    sr_d[s] <= sr_d[s-1];
                    sr_v[s] <= sr_v[s-1];
                end
            end
        end

        for (genvar i = 0; i < ROWS; i++) begin : g_tap
            assign w_tap[i][j]   = sr_d[i+j];
            assign w_tap_v[i][j] = sr_v[i+j];
        end
    end

    // Each PE accumulates only when both incoming operands carry a valid tag.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                if (rst || clear_acc) begin
                    acc[i][j] <= '0;
                end else if (a_tap_v[i][j] && w_tap_v[i][j]) begin
                    acc[i][j] <= acc[i][j] + mac_term(a_tap[i][j], w_tap[i][j]);
                end
            end
        end
    end

    // Job control: accept beats, wait for the wavefront to clear the array, then stream rows.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k_lat     <= '0;
            kc        <= '0;
            dc        <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        k_lat   <= k_len;
                        kc      <= '0;
                        busy    <= 1'b1;
                        out_idx <= '0;
                        if (k_len == '0) begin
                            state     <= OUT;
                            out_valid <= 1'b1;
                        end else begin
                            state    <= LOAD;
                            in_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        kc <= kc + KW'(1);
                        if (kc == k_lat - KW'(1)) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                            dc       <= DW'(ROWS + COLS - 2);
                        end
                    end
                end
                DRAIN: begin
                    if (dc == '0) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        out_idx   <= '0;
                    end else begin
                        dc <= dc - DW'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        if (out_idx == IW'(ROWS - 1)) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_idx   <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            out_idx <= out_idx + IW'(1);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Present the accumulators of the selected row; they are frozen during readout.
    always_comb begin
        out_row = '0;
        for (int j = 0; j < COLS; j++) begin
            out_row[j*ACC_W +: ACC_W] = acc[out_idx][j];
        end
    end

endmodule
